// File: rtl/noc_axi4_bridge_ser.sv
// -----------------------------------------------------------------------------
// noc_axi4_bridge_ser
//
// Response-path serializer of the NoC-to-AXI4 bridge. One response message
// (header + full AXI4 data line) is accepted per handshake and emitted on the
// outbound NoC channel as one header flit followed by N payload flits, where
// N is the header MSG_LENGTH field clamped to MAX_FLITS. Oversized lengths are
// flagged by a one-cycle len_err pulse.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst           in   synchronous reset, active-high
//   header_in     in   response header; [63:0] is the header flit
//   data_in       in   response data line; payload flit i = data_in[i*64 +: 64]
//   in_val        in   header_in/data_in valid
//   in_rdy        out  serializer idle and able to accept a message
//   flit_out      out  outbound flit (registered)
//   flit_out_val  out  flit_out valid (registered)
//   flit_out_rdy  in   NoC accepts the current flit
//   len_err       out  one-cycle pulse: accepted message had length > MAX_FLITS
// -----------------------------------------------------------------------------
module noc_axi4_bridge_ser #(
    parameter bit SWAP_ENDIANESS    = 1'b0,
    parameter int NOC_DATA_WIDTH    = 64,
    parameter int AXI4_DATA_WIDTH   = 512,
    parameter int MSG_HEADER_WIDTH  = 192,
    // Position of the MSG_LENGTH field inside the header flit.
    parameter int MSG_LENGTH_LO     = 22,
    parameter int MSG_LENGTH_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MSG_HEADER_WIDTH-1:0] header_in,
    input  logic [AXI4_DATA_WIDTH-1:0]  data_in,
    input  logic                        in_val,
    output logic                        in_rdy,
    output logic [NOC_DATA_WIDTH-1:0]   flit_out,
    output logic                        flit_out_val,
    input  logic                        flit_out_rdy,
    output logic                        len_err
);

    localparam int MAX_FLITS = AXI4_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int IDX_W     = $clog2(MAX_FLITS);
    localparam int CNT_W     = $clog2(MAX_FLITS + 1);
    localparam int BYTES     = NOC_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_HDR,
        S_SEND_DATA
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t                                  r_state;
    logic [MAX_FLITS-1:0][NOC_DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]                        r_remaining;
    logic [IDX_W-1:0]                        r_idx;
    logic                                    r_in_rdy;
    logic                                    r_flit_val;
    logic [NOC_DATA_WIDTH-1:0]               r_flit;
    logic                                    r_len_err;

    // -------------------------------------------------------------------------
    // Header decode and length clamp (from the live input, used on accept)
    // -------------------------------------------------------------------------
    logic [MSG_LENGTH_WIDTH-1:0] w_len;
    logic                        w_len_over;
    logic [CNT_W-1:0]            w_len_clamped;
    logic [NOC_DATA_WIDTH-1:0]   w_hdr_flit;
    logic                        w_unused_hdr_hi;

    assign w_len         = header_in[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH];
    assign w_len_over    = (w_len > MSG_LENGTH_WIDTH'(MAX_FLITS));
    assign w_len_clamped = w_len_over ? CNT_W'(MAX_FLITS) : w_len[CNT_W-1:0];

    // Only the low header word travels on the NoC; the rest of the header is
    // consumed upstream.
    assign w_unused_hdr_hi = ^header_in[MSG_HEADER_WIDTH-1:NOC_DATA_WIDTH];

    // Header flit goes out with the clamped count so the receiver never
    // expects more payload flits than are actually sent.
    always_comb begin
        w_hdr_flit = header_in[NOC_DATA_WIDTH-1:0];
        w_hdr_flit[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH] = MSG_LENGTH_WIDTH'(w_len_clamped);
    end

    // -------------------------------------------------------------------------
    // Next payload flit selection
    // -------------------------------------------------------------------------
    // r_idx names the payload flit currently on flit_out while in SEND_DATA;
    // in SEND_HDR it is still 0, so the first payload flit is r_idx itself.
    logic [IDX_W-1:0]          w_sel_idx;
    logic [NOC_DATA_WIDTH-1:0] w_raw;
    logic [NOC_DATA_WIDTH-1:0] w_swapped;
    logic [NOC_DATA_WIDTH-1:0] w_payload;

    assign w_sel_idx = (r_state == S_SEND_HDR) ? r_idx : (r_idx + IDX_W'(1));
    assign w_raw     = r_data[w_sel_idx];

    always_comb begin
        w_swapped = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_swapped[8*k +: 8] = w_raw[8*(BYTES-1-k) +: 8];
        end
    end

    assign w_payload = SWAP_ENDIANESS ? w_swapped : w_raw;

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, exactly like hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            // NOTE: the data capture register is cleared on reset as well, so
            // no stale line from an aborted message is ever observable.
            r_data      <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
            r_in_rdy    <= 1'b1;
            r_flit_val  <= 1'b0;
            r_flit      <= '0;
            r_len_err   <= 1'b0;
        end else begin
            // len_err is a pulse: it is only raised by an accept below.
            r_len_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // in_rdy is high throughout IDLE, so in_val alone accepts.
                    if (in_val) begin
                        r_data      <= data_in;
                        r_flit      <= w_hdr_flit;
                        r_remaining <= w_len_clamped;
                        r_idx       <= '0;
                        r_len_err   <= w_len_over;
                        r_flit_val  <= 1'b1;
                        r_in_rdy    <= 1'b0;
                        r_state     <= S_SEND_HDR;
                    end
                end

                S_SEND_HDR: begin
                    if (flit_out_rdy) begin
                        if (r_remaining != '0) begin
                            r_flit  <= w_payload;
                            r_state <= S_SEND_DATA;
                        end else begin
                            r_flit_val <= 1'b0;
                            r_in_rdy   <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end

                S_SEND_DATA: begin
                    if (flit_out_rdy) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_flit_val <= 1'b0;
                            r_in_rdy   <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx  <= r_idx + IDX_W'(1);
                            r_flit <= w_payload;
                        end
                    end
                end

                default: begin
                    r_flit_val <= 1'b0;
                    r_in_rdy   <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_rdy       = r_in_rdy;
    assign flit_out     = r_flit;
    assign flit_out_val = r_flit_val;
    assign len_err      = r_len_err;

endmodule

// File: tb/tb_noc_axi4_bridge_ser.sv
// -----------------------------------------------------------------------------
// Bench for noc_axi4_bridge_ser. Two instances (byte swap off / on) share all
// inputs. A queue-based model predicts every flit each instance must emit and
// is compared against both instances on every falling edge; directed tests add
// literal expectations for latency, flit values and boundary lengths.
// -----------------------------------------------------------------------------
module tb_noc_axi4_bridge_ser;

    localparam int NW     = 64;
    localparam int AW     = 512;
    localparam int HW     = 192;
    localparam int LEN_LO = 22;
    localparam int MAXF   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [HW-1:0] header_in = '0;
    logic [AW-1:0] data_in = '0;
    logic          in_val = 1'b0;
    logic          flit_out_rdy = 1'b1;

    logic          in_rdy0, flit_val0, len_err0;
    logic [NW-1:0] flit0;
    logic          in_rdy1, flit_val1, len_err1;
    logic [NW-1:0] flit1;

    noc_axi4_bridge_ser #(.SWAP_ENDIANESS(1'b0)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .header_in    (header_in),
        .data_in      (data_in),
        .in_val       (in_val),
        .in_rdy       (in_rdy0),
        .flit_out     (flit0),
        .flit_out_val (flit_val0),
        .flit_out_rdy (flit_out_rdy),
        .len_err      (len_err0)
    );

    noc_axi4_bridge_ser #(.SWAP_ENDIANESS(1'b1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .header_in    (header_in),
        .data_in      (data_in),
        .in_val       (in_val),
        .in_rdy       (in_rdy1),
        .flit_out     (flit1),
        .flit_out_val (flit_val1),
        .flit_out_rdy (flit_out_rdy),
        .len_err      (len_err1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // -------------------------------------------------------------------------
    // Model: a message becomes a list of flits; each handshake pops one.
    // -------------------------------------------------------------------------
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        exp_len_err = 1'b0;
    logic [63:0] got0[$];
    logic [63:0] got1[$];
    int          len_err_cycles = 0;

    // Reverse the byte order by shifting bytes in from the least significant end.
    function automatic logic [63:0] byte_rev(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = (r << 8) | 64'(x[8*k +: 8]);
        return r;
    endfunction

    task automatic model_accept(input logic [HW-1:0] hdr, input logic [AW-1:0] d);
        int          len;
        int          n;
        logic [63:0] h;
        len = int'(hdr[LEN_LO +: 8]);
        n   = (len > MAXF) ? MAXF : len;
        h   = hdr[63:0];
        h[LEN_LO +: 8] = 8'(n);
        q0.push_back(h);
        q1.push_back(h);
        for (int k = 0; k < n; k++) begin
            q0.push_back(d[64*k +: 64]);
            q1.push_back(byte_rev(d[64*k +: 64]));
        end
        exp_len_err = (len > MAXF);
    endtask

    // Compare, capture, then advance the model to the state after the next edge.
    initial begin
        logic was_idle;
        forever begin
            @(negedge clk);
            check("in_rdy0",  in_rdy0,   q0.size() == 0);
            check("flit_val0", flit_val0, q0.size() != 0);
            check("len_err0", len_err0,  exp_len_err);
            if (q0.size() != 0) check("flit0", flit0, q0[0]);
            check("in_rdy1",  in_rdy1,   q1.size() == 0);
            check("flit_val1", flit_val1, q1.size() != 0);
            check("len_err1", len_err1,  exp_len_err);
            if (q1.size() != 0) check("flit1", flit1, q1[0]);

            if (flit_val0 && flit_out_rdy) got0.push_back(flit0);
            if (flit_val1 && flit_out_rdy) got1.push_back(flit1);
            if (len_err0) len_err_cycles++;

            if (rst) begin
                q0.delete();
                q1.delete();
                exp_len_err = 1'b0;
            end else begin
                was_idle    = (q0.size() == 0);
                exp_len_err = 1'b0;
                if (!was_idle && flit_out_rdy) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end else if (was_idle && in_val) begin
                    model_accept(header_in, data_in);
                end
            end
        end
    end

    // flit_out_rdy driver: 0 = always ready, 1 = random, 2 = driven by test.
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      flit_out_rdy = 1'b1;
            else if (rdy_mode == 1) flit_out_rdy = 1'($urandom_range(0, 1));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // -------------------------------------------------------------------------
    function automatic logic [HW-1:0] make_hdr(input logic [63:0] lo, input logic [7:0] len);
        logic [HW-1:0] h;
        for (int i = 0; i < HW / 32; i++) h[32*i +: 32] = $urandom;
        h[63:0] = lo;
        h[LEN_LO +: 8] = len;
        return h;
    endfunction

    function automatic logic [AW-1:0] rand_data();
        logic [AW-1:0] d;
        for (int i = 0; i < AW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Present a message for one cycle; optionally wait for in_rdy to return.
    // cycles = number of cycles from acceptance until in_rdy is seen high.
    task automatic send(input logic [HW-1:0] hdr, input logic [AW-1:0] d,
                        input bit wait_done, output int cycles);
        int w;
        w = 0;
        while (!in_rdy0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) timeout_fail("wait_in_rdy");
        header_in = hdr;
        data_in   = d;
        in_val    = 1'b1;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        cycles = 1;
        if (wait_done) begin
            while (!in_rdy0 && cycles < 200) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            if (cycles >= 200) timeout_fail("wait_done");
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    initial begin
        logic [AW-1:0] d;
        logic [AW-1:0] d2;
        int            cyc;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_rdy",  in_rdy0,   1'b1);
        check("rst_val",     flit_val0, 1'b0);
        check("rst_flit",    flit0,     64'h0);
        check("rst_len_err", len_err0,  1'b0);

        // Length 8, bytes 0x00..0x3F, always ready
        for (int b = 0; b < 64; b++) d[8*b +: 8] = 8'(b);
        got0.delete(); got1.delete(); len_err_cycles = 0;
        send(make_hdr(64'h1122_3344_0000_0000, 8'd8), d, 1'b1, cyc);
        check("len8_in_rdy_cycle", 64'(cyc), 64'd10);
        check("len8_count0", 64'(got0.size()), 64'd9);
        check("len8_count1", 64'(got1.size()), 64'd9);
        if (got0.size() == 9 && got1.size() == 9) begin
            check("len8_hdr0",       got0[0], 64'h1122_3344_0200_0000);
            check("len8_hdr1",       got1[0], 64'h1122_3344_0200_0000);
            check("len8_flit0_sw0",  got0[1], 64'h0706_0504_0302_0100);
            check("len8_flit7_sw0",  got0[8], 64'h3F3E_3D3C_3B3A_3938);
            check("len8_flit0_sw1",  got1[1], 64'h0001_0203_0405_0607);
            check("len8_flit7_sw1",  got1[8], 64'h3839_3A3B_3C3D_3E3F);
        end
        check("len8_no_len_err", 64'(len_err_cycles), 64'd0);

        // Length 0: header only, back-to-back accept after 2 cycles
        got0.delete(); got1.delete();
        send(make_hdr(64'hDEAD_BEEF_C03F_FFFF, 8'd0), rand_data(), 1'b1, cyc);
        check("len0_period", 64'(cyc), 64'd2);
        send(make_hdr(64'hDEAD_BEEF_C03F_FFFF, 8'd0), rand_data(), 1'b1, cyc);
        check("len0_period2", 64'(cyc), 64'd2);
        check("len0_count", 64'(got0.size()), 64'd2);
        if (got0.size() == 2) check("len0_hdr", got0[0], 64'hDEAD_BEEF_C03F_FFFF);

        // Length 2 with random backpressure
        got0.delete(); got1.delete();
        d = rand_data();
        rdy_mode = 1;
        send(make_hdr(64'h0, 8'd2), d, 1'b1, cyc);
        rdy_mode = 0;
        check("len2_count", 64'(got0.size()), 64'd3);
        if (got0.size() == 3) begin
            check("len2_hdr",   got0[0], 64'h0000_0000_0080_0000);
            check("len2_flit0", got0[1], d[63:0]);
            check("len2_flit1", got0[2], d[127:64]);
        end

        // Length 12: clamp to 8 and pulse len_err once
        got0.delete(); got1.delete(); len_err_cycles = 0;
        send(make_hdr(64'h0, 8'd12), rand_data(), 1'b1, cyc);
        check("len12_len_err_pulses", 64'(len_err_cycles), 64'd1);
        check("len12_count", 64'(got0.size()), 64'd9);
        if (got0.size() == 9) check("len12_hdr", got0[0], 64'h0000_0000_0200_0000);

        // Length 9: one past the boundary
        got0.delete(); got1.delete(); len_err_cycles = 0;
        send(make_hdr(64'h0, 8'd9), rand_data(), 1'b1, cyc);
        check("len9_len_err_pulses", 64'(len_err_cycles), 64'd1);
        check("len9_count", 64'(got0.size()), 64'd9);

        // Reset while payload flit 3 is stalled
        d = rand_data();
        rdy_mode = 2;
        flit_out_rdy = 1'b1;
        send(make_hdr(64'h0, 8'd8), d, 1'b0, cyc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        flit_out_rdy = 1'b0;
        check("stall_flit3", flit0, d[3*64 +: 64]);
        @(posedge clk);
        #1;
        check("stall_flit3_hold", flit0, d[3*64 +: 64]);
        check("stall_val_hold", flit_val0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_val",    flit_val0, 1'b0);
        check("abort_in_rdy", in_rdy0,   1'b1);
        rdy_mode = 0;
        flit_out_rdy = 1'b1;
        got0.delete(); got1.delete();
        d2 = rand_data();
        send(make_hdr(64'h0, 8'd1), d2, 1'b1, cyc);
        check("after_rst_period", 64'(cyc), 64'd3);
        check("after_rst_count", 64'(got0.size()), 64'd2);
        if (got0.size() == 2) begin
            check("after_rst_flit0",    got0[1], d2[63:0]);
            check("after_rst_flit0_sw", got1[1], byte_rev(d2[63:0]));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
